// File: rtl/i2c_ctrl_pkg.sv
// Shared constants for the I2C transaction scheduler: master register map,
// status bit positions, completion codes and scheduler state encoding.
package i2c_ctrl_pkg;

  localparam logic [7:0] OFS_START  = 8'h00;
  localparam logic [7:0] OFS_CLKDIV = 8'h04;
  localparam logic [7:0] OFS_SADDR  = 8'h08;
  localparam logic [7:0] OFS_TX     = 8'h0C;
  localparam logic [7:0] OFS_RX     = 8'h10;
  localparam logic [7:0] OFS_STATUS = 8'h14;
  localparam logic [7:0] OFS_MODE   = 8'h18;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_NACK_BIT = 1;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_DIV,
    ST_WR_SADDR,
    ST_WR_DATA,
    ST_WR_MODE,
    ST_WR_START,
    ST_POLL_RD,
    ST_POLL_CHK,
    ST_RD_DATA,
    ST_RD_WAIT,
    ST_WR_STOP,
    ST_CLR_STAT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/i2c_txn_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the lowest requesting index at or after
// the pointer wins. The pointer register lives in the scheduler.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!valid_o && req_i[j]) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler that owns the I2C master's register port and runs
// one whole single-byte transaction per grant, returning data and status.
module i2c_txn_scheduler
  import i2c_ctrl_pkg::*;
#(
  parameter int          NREQ    = 4,
  parameter logic [7:0]  CLK_DIV = 8'd100,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_saddr,
  input  logic [NREQ-1:0]   req_mode,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              busy,
  output logic              m_wr,
  output logic [7:0]        m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  // state       | meaning
  // IDLE        | waiting for a request; winner latched here
  // WR_* states | one-cycle register writes (div, saddr, tx, mode, start, stop)
  // POLL_RD/CHK | present status, then evaluate it (done / nack / timeout)
  // RD_DATA/WAIT| present rx byte, then capture it
  // CLR_STAT    | clear status; DONE pulses done[idx] and advances the pointer

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          div_written_q, div_written_d;
  logic [6:0]    saddr_q, saddr_d;
  logic          mode_q, mode_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [1:0]    err_q, err_d;

  logic [NREQ-1:0] gnt_oh;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_valid;
  logic [15:0]     cnt_inc;
  logic            unused_rdata_hi;

  assign unused_rdata_hi = ^m_rdata[31:8];
  assign cnt_inc         = cnt_q + 16'd1;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (gnt_oh),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      idx_q         <= '0;
      div_written_q <= 1'b0;
      saddr_q       <= '0;
      mode_q        <= 1'b0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      err_q         <= ERR_OK;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      div_written_q <= div_written_d;
      saddr_q       <= saddr_d;
      mode_q        <= mode_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    div_written_d = div_written_q;
    saddr_d       = saddr_q;
    mode_d        = mode_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    done          = '0;
    m_wr          = 1'b0;
    m_addr        = 8'h00;
    m_wdata       = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          idx_d   = gnt_idx;
          for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
              saddr_d = req_saddr[7*i +: 7];
              mode_d  = req_mode[i];
              wdata_d = req_wdata[8*i +: 8];
            end
          end
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = ERR_OK;
          state_d = div_written_q ? ST_WR_SADDR : ST_WR_DIV;
        end
      end
      ST_WR_DIV: begin
        m_wr          = 1'b1;
        m_addr        = OFS_CLKDIV;
        m_wdata       = {24'h0, CLK_DIV};
        div_written_d = 1'b1;
        state_d       = ST_WR_SADDR;
      end
      ST_WR_SADDR: begin
        m_wr    = 1'b1;
        m_addr  = OFS_SADDR;
        m_wdata = {25'h0, saddr_q};
        state_d = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        m_wr    = 1'b1;
        m_addr  = OFS_TX;
        m_wdata = {24'h0, wdata_q};
        state_d = ST_WR_MODE;
      end
      ST_WR_MODE: begin
        m_wr    = 1'b1;
        m_addr  = OFS_MODE;
        m_wdata = {31'h0, mode_q};
        state_d = ST_WR_START;
      end
      ST_WR_START: begin
        m_wr    = 1'b1;
        m_addr  = OFS_START;
        m_wdata = 32'd1;
        state_d = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        m_addr  = OFS_STATUS;
        state_d = ST_POLL_CHK;
      end
      ST_POLL_CHK: begin
        // NACK outranks done; timeout only when neither bit is reported
        if (m_rdata[STAT_NACK_BIT]) begin
          err_d   = ERR_NACK;
          state_d = ST_WR_STOP;
        end else if (m_rdata[STAT_DONE_BIT]) begin
          state_d = mode_q ? ST_RD_DATA : ST_WR_STOP;
        end else if (cnt_inc == TIMEOUT) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_WR_STOP;
        end else begin
          cnt_d   = cnt_inc;
          state_d = ST_POLL_RD;
        end
      end
      ST_RD_DATA: begin
        m_addr  = OFS_RX;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rdata_d = m_rdata[7:0];
        state_d = ST_WR_STOP;
      end
      ST_WR_STOP: begin
        m_wr    = 1'b1;
        m_addr  = OFS_START;
        state_d = ST_CLR_STAT;
      end
      ST_CLR_STAT: begin
        m_wr    = 1'b1;
        m_addr  = OFS_STATUS;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done[idx_q] = 1'b1;
        ptr_d       = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
